// File: rtl/mcu_single_cycle_lcd.sv
// Rotary/button controlled 8-bit value register with HD44780-style 4-bit LCD
// front end that prints the value as two hex digits.
module mcu_single_cycle_lcd #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned DEB_CYC = 50_000
) (
  input  logic       clk_in,
  input  logic       nClear,
  input  logic       clk_en,
  input  logic       btn,
  input  logic       rot_a,
  input  logic       rot_b,
  output logic [7:0] display,
  output logic [3:0] lcd_dataout,
  output logic [2:0] lcd_control
);

  function automatic int unsigned at_least_1(input int unsigned n);
    return (n == 0) ? 1 : n;
  endfunction

  // LCD delays in clock cycles; scaled before multiplying to stay in 32 bits
  localparam int unsigned T_PWR    = at_least_1((CLK_HZ / 1000) * 15);
  localparam int unsigned T_4M1    = at_least_1((CLK_HZ / 10000) * 41);
  localparam int unsigned T_100U   = at_least_1(CLK_HZ / 10000);
  localparam int unsigned T_40U    = at_least_1(CLK_HZ / 25000);
  localparam int unsigned T_1U     = at_least_1(CLK_HZ / 1000000);
  localparam int unsigned T_1M64   = at_least_1((CLK_HZ / 100000) * 164);
  localparam int unsigned T_SETUP  = 2;
  localparam int unsigned T_STROBE = 12;
  localparam int unsigned T_HOLD   = 2;
  localparam int unsigned DEB_LIM  = at_least_1(DEB_CYC);
  localparam int unsigned DW       = $clog2(DEB_LIM + 1);

  // ---------------------------------------------------------------------------
  // Input conditioning: bit 0 = btn, bit 1 = rot_a, bit 2 = rot_b
  // ---------------------------------------------------------------------------
  logic [2:0]    raw, sync1, sync2, deb;
  logic [1:0]    deb_prev;
  logic [DW-1:0] deb_cnt [3];

  assign raw = {rot_b, rot_a, btn};

  // Two-flop synchronizers followed by stable-time debouncers
  always_ff @(posedge clk_in or posedge nClear) begin
    if (nClear) begin
      sync1    <= '0;
      sync2    <= '0;
      deb      <= '0;
      deb_prev <= '0;
      for (int unsigned i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else if (clk_en) begin
      sync1    <= raw;
      sync2    <= sync1;
      deb_prev <= deb[1:0];
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_LIM - 1)) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic       btn_rise, a_rise;
  logic [7:0] v;

  assign btn_rise = deb[0] & ~deb_prev[0];
  assign a_rise   = deb[1] & ~deb_prev[1];

  // Value register: button clears (and wins), rot_a edge steps by rot_b direction
  always_ff @(posedge clk_in or posedge nClear) begin
    if (nClear) begin
      v <= '0;
    end else if (clk_en) begin
      if (btn_rise)    v <= '0;
      else if (a_rise) v <= deb[2] ? v - 8'd1 : v + 8'd1;
    end
  end

  assign display = v;

  // ---------------------------------------------------------------------------
  // LCD sequencer
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, SET_ADDR, WR_HI, WR_LO, DONE} lcd_state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_HOLD, PH_WAIT} phase_t;

  lcd_state_t  state, state_n;
  phase_t      phase, phase_n;
  logic [31:0] timer, timer_n, wait_cur;
  logic [3:0]  step, step_n;
  logic [7:0]  wr_val, wr_val_n, last_val, last_val_n;
  logic [3:0]  nib_q;
  logic        rs_q, e_q, e_n;
  logic [4:0]  cmd_n;

  function automatic logic [7:0] hex_char(input logic [3:0] d);
    return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
  endfunction

  // {RS, nibble} presented while in state st at step stp.
  // INIT steps 0..3 are the single wake-up nibbles, 4..11 the four config bytes.
  function automatic logic [4:0] cmd_of(input lcd_state_t st, input logic [3:0] stp,
                                        input logic [7:0] val);
    logic [7:0] b;
    logic [4:0] c;
    b = 8'h00;
    c = 5'h00;
    case (st)
      INIT: begin
        case (stp)
          4'd0, 4'd1, 4'd2:  c = 5'h03;
          4'd3, 4'd4:        c = 5'h02;
          4'd5:              c = 5'h08;
          4'd6, 4'd8, 4'd10: c = 5'h00;
          4'd7:              c = 5'h06;
          4'd9:              c = 5'h0C;
          default:           c = 5'h01;
        endcase
      end
      SET_ADDR, WR_HI, WR_LO: begin
        if (st == SET_ADDR)   b = 8'h80;
        else if (st == WR_HI) b = hex_char(val[7:4]);
        else                  b = hex_char(val[3:0]);
        c = {st != SET_ADDR, stp[0] ? b[3:0] : b[7:4]};
      end
      default: c = 5'h00;
    endcase
    return c;
  endfunction

  // Wait after the hold phase: 1 us between byte halves, 40 us after a byte
  function automatic logic [31:0] wait_of(input lcd_state_t st, input logic [3:0] stp);
    logic [31:0] w;
    w = 32'(T_40U);
    if (st == INIT) begin
      case (stp)
        4'd0:                         w = 32'(T_4M1);
        4'd1:                         w = 32'(T_100U);
        4'd2, 4'd3, 4'd5, 4'd7, 4'd9: w = 32'(T_40U);
        4'd4, 4'd6, 4'd8, 4'd10:      w = 32'(T_1U);
        default:                      w = 32'(T_1M64);
      endcase
    end else if (!stp[0]) begin
      w = 32'(T_1U);
    end
    return w;
  endfunction

  // Next-state logic: each nibble runs setup -> strobe -> hold -> wait.
  // Outputs are registered from the next-state values so data, RS and E
  // change together with the phase that owns them.
  always_comb begin
    state_n    = state;
    phase_n    = phase;
    timer_n    = timer + 32'd1;
    step_n     = step;
    wr_val_n   = wr_val;
    last_val_n = last_val;
    wait_cur   = wait_of(state, step);
    case (state)
      PWR_WAIT: begin
        if (timer == 32'(T_PWR - 1)) begin
          state_n = INIT;
          phase_n = PH_SETUP;
          step_n  = '0;
          timer_n = '0;
        end
      end
      IDLE: begin
        timer_n = '0;
        if (v != last_val) begin
          state_n  = SET_ADDR;
          phase_n  = PH_SETUP;
          step_n   = '0;
          wr_val_n = v;
        end
      end
      DONE: begin
        timer_n    = '0;
        last_val_n = wr_val;
        state_n    = IDLE;
      end
      INIT, SET_ADDR, WR_HI, WR_LO: begin
        case (phase)
          PH_SETUP: if (timer == 32'(T_SETUP - 1)) begin
            phase_n = PH_STROBE;
            timer_n = '0;
          end
          PH_STROBE: if (timer == 32'(T_STROBE - 1)) begin
            phase_n = PH_HOLD;
            timer_n = '0;
          end
          PH_HOLD: if (timer == 32'(T_HOLD - 1)) begin
            phase_n = PH_WAIT;
            timer_n = '0;
          end
          default: if (timer == wait_cur - 32'd1) begin
            phase_n = PH_SETUP;
            timer_n = '0;
            if (state == INIT) begin
              if (step == 4'd11) begin
                state_n  = SET_ADDR;
                step_n   = '0;
                wr_val_n = v;
              end else begin
                step_n = step + 4'd1;
              end
            end else if (!step[0]) begin
              step_n = 4'd1;
            end else begin
              step_n = '0;
              case (state)
                SET_ADDR: state_n = WR_HI;
                WR_HI:    state_n = WR_LO;
                default:  state_n = DONE;
              endcase
            end
          end
        endcase
      end
      default: begin
        state_n = PWR_WAIT;
        phase_n = PH_SETUP;
        timer_n = '0;
      end
    endcase
    cmd_n = cmd_of(state_n, step_n, wr_val_n);
    e_n   = (phase_n == PH_STROBE) &&
            (state_n == INIT || state_n == SET_ADDR || state_n == WR_HI || state_n == WR_LO);
  end

  // LCD sequencer state and output registers
  always_ff @(posedge clk_in or posedge nClear) begin
    if (nClear) begin
      state    <= PWR_WAIT;
      phase    <= PH_SETUP;
      timer    <= '0;
      step     <= '0;
      wr_val   <= '0;
      last_val <= '0;
      nib_q    <= '0;
      rs_q     <= 1'b0;
      e_q      <= 1'b0;
    end else if (clk_en) begin
      state    <= state_n;
      phase    <= phase_n;
      timer    <= timer_n;
      step     <= step_n;
      wr_val   <= wr_val_n;
      last_val <= last_val_n;
      nib_q    <= cmd_n[3:0];
      rs_q     <= cmd_n[4];
      e_q      <= e_n;
    end
  end

  assign lcd_dataout = nib_q;
  assign lcd_control = {e_q, rs_q, 1'b0};

endmodule

// File: tb/tb_mcu_single_cycle_lcd.sv
// Self-checking bench for mcu_single_cycle_lcd at a scaled clock (1 MHz).
`timescale 1ns/1ps
module tb_mcu_single_cycle_lcd;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned DEB    = 16;
  localparam int unsigned HOLD   = 40;

  logic       clk_in = 1'b0;
  logic       nClear = 1'b1;
  logic       clk_en = 1'b1;
  logic       btn    = 1'b0;
  logic       rot_a  = 1'b0;
  logic       rot_b  = 1'b0;
  logic [7:0] display;
  logic [3:0] lcd_dataout;
  logic [2:0] lcd_control;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  mcu_single_cycle_lcd #(.CLK_HZ(CLK_HZ), .DEB_CYC(DEB)) dut (
    .clk_in     (clk_in),
    .nClear     (nClear),
    .clk_en     (clk_en),
    .btn        (btn),
    .rot_a      (rot_a),
    .rot_b      (rot_b),
    .display    (display),
    .lcd_dataout(lcd_dataout),
    .lcd_control(lcd_control)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ascii_hex(input logic [3:0] d);
    if (d <= 4'd9) return 8'h30 + 8'(d);
    return 8'h41 + 8'(d - 4'd10);
  endfunction

  // ---------------- LCD strobe monitor ----------------
  typedef struct {
    logic        rs;
    logic [3:0]  nib;
    int unsigned gap;
  } strobe_t;

  strobe_t     cap[$];
  logic        en_q = 1'b0;
  logic        e_prev = 1'b0;
  logic        rs_at_rise = 1'b0;
  logic [3:0]  nib_at_rise = 4'h0;
  int unsigned ecyc = 0;
  int unsigned last_rise = 0;
  int unsigned e_width = 0;

  always @(posedge clk_in) begin
    en_q <= clk_en && !nClear;
    if (clk_en && !nClear) ecyc <= ecyc + 1;
  end

  always @(negedge clk_in) begin
    if (nClear) begin
      e_prev  <= 1'b0;
      e_width <= 0;
    end else if (en_q) begin
      e_prev <= lcd_control[2];
      if (lcd_control[2] && !e_prev) begin
        cap.push_back('{rs: lcd_control[1], nib: lcd_dataout, gap: ecyc - last_rise});
        last_rise   <= ecyc;
        e_width     <= 1;
        rs_at_rise  <= lcd_control[1];
        nib_at_rise <= lcd_dataout;
        check("rw_low", 32'(lcd_control[0]), 32'd0);
      end else if (lcd_control[2]) begin
        e_width <= e_width + 1;
      end else if (e_prev) begin
        check("e_width", e_width, 32'd12);
        check("e_data_hold", 32'({lcd_control[1], lcd_dataout}), 32'({rs_at_rise, nib_at_rise}));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  typedef enum int {OP_INC, OP_DEC, OP_BTN, OP_BTN_BOUNCE, OP_BOTH, OP_LCD} op_t;
  typedef struct {
    op_t        op;
    logic [7:0] exp_v;
  } vec_t;

  typedef struct {
    logic        rs;
    logic [3:0]  nib;
    int unsigned gap;
  } init_t;

  task automatic cycles(input int unsigned n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic press(input bit bounce);
    if (bounce) repeat (4) begin btn = 1'b1; cycles(3); btn = 1'b0; cycles(2); end
    btn = 1'b1; cycles(250);
    if (bounce) repeat (4) begin btn = 1'b0; cycles(2); btn = 1'b1; cycles(3); end
    btn = 1'b0; cycles(HOLD);
  endtask

  task automatic do_op(input op_t op);
    case (op)
      OP_INC: begin
        rot_a = 1'b1; cycles(HOLD); rot_b = 1'b1; cycles(HOLD);
        rot_a = 1'b0; cycles(HOLD); rot_b = 1'b0; cycles(HOLD);
      end
      OP_DEC: begin
        rot_b = 1'b1; cycles(HOLD); rot_a = 1'b1; cycles(HOLD);
        rot_b = 1'b0; cycles(HOLD); rot_a = 1'b0; cycles(HOLD);
      end
      OP_BTN:        press(1'b0);
      OP_BTN_BOUNCE: press(1'b1);
      OP_BOTH: begin
        btn = 1'b1; rot_a = 1'b1; cycles(HOLD);
        btn = 1'b0; cycles(HOLD);
        rot_b = 1'b1; cycles(HOLD); rot_a = 1'b0; cycles(HOLD); rot_b = 1'b0; cycles(HOLD);
      end
      default: ;
    endcase
  endtask

  task automatic wait_e_high(input string name);
    int unsigned k = 0;
    while (!lcd_control[2] && k < 2000) begin cycles(1); k++; end
    check(name, 32'(lcd_control[2]), 32'd1);
  endtask

  task automatic wait_quiet();
    int unsigned k = 0;
    cycles(5);
    while ((ecyc - last_rise) < 300 && k < 20000) begin cycles(1); k++; end
    check("lcd_quiet_in_time", 32'(k < 20000), 32'd1);
  endtask

  task automatic check_lcd(input logic [7:0] exp);
    int n;
    logic [7:0] hi, lo;
    wait_quiet();
    n  = cap.size();
    hi = ascii_hex(exp[7:4]);
    lo = ascii_hex(exp[3:0]);
    check("lcd_enough_strobes", 32'(n >= 6), 32'd1);
    if (n >= 6) begin
      check("lcd_addr_byte", 32'({cap[n-6].rs, cap[n-5].rs, cap[n-6].nib, cap[n-5].nib}),
            32'({2'b00, 8'h80}));
      check("lcd_hi_char", 32'({cap[n-4].rs, cap[n-3].rs, cap[n-4].nib, cap[n-3].nib}),
            32'({2'b11, hi}));
      check("lcd_lo_char", 32'({cap[n-2].rs, cap[n-1].rs, cap[n-2].nib, cap[n-1].nib}),
            32'({2'b11, lo}));
    end
  endtask

  // ---------------- test sequence ----------------
  vec_t        vecs [17];
  init_t       init_tab [18];
  logic [7:0]  v_model;
  logic [7:0]  snap_disp;
  logic [3:0]  snap_data;
  logic [2:0]  snap_ctrl;

  initial begin
    int unsigned k;
    int unsigned r;

    // Power-on sequence: nibble, RS, rise-to-rise gap = 12 E + 2 hold + wait + 2 setup
    init_tab[0]  = '{1'b0, 4'h3, 0};
    init_tab[1]  = '{1'b0, 4'h3, 16 + 4100};
    init_tab[2]  = '{1'b0, 4'h3, 16 + 100};
    init_tab[3]  = '{1'b0, 4'h2, 16 + 40};
    init_tab[4]  = '{1'b0, 4'h2, 16 + 40};
    init_tab[5]  = '{1'b0, 4'h8, 16 + 1};
    init_tab[6]  = '{1'b0, 4'h0, 16 + 40};
    init_tab[7]  = '{1'b0, 4'h6, 16 + 1};
    init_tab[8]  = '{1'b0, 4'h0, 16 + 40};
    init_tab[9]  = '{1'b0, 4'hC, 16 + 1};
    init_tab[10] = '{1'b0, 4'h0, 16 + 40};
    init_tab[11] = '{1'b0, 4'h1, 16 + 1};
    init_tab[12] = '{1'b0, 4'h8, 16 + 1640};
    init_tab[13] = '{1'b0, 4'h0, 16 + 1};
    init_tab[14] = '{1'b1, 4'h3, 16 + 40};
    init_tab[15] = '{1'b1, 4'h0, 16 + 1};
    init_tab[16] = '{1'b1, 4'h3, 16 + 40};
    init_tab[17] = '{1'b1, 4'h0, 16 + 1};

    vecs[0]  = '{OP_INC,        8'h01};
    vecs[1]  = '{OP_INC,        8'h02};
    vecs[2]  = '{OP_BTN_BOUNCE, 8'h00};
    vecs[3]  = '{OP_DEC,        8'hFF};
    vecs[4]  = '{OP_DEC,        8'hFE};
    vecs[5]  = '{OP_DEC,        8'hFD};
    vecs[6]  = '{OP_DEC,        8'hFC};
    vecs[7]  = '{OP_DEC,        8'hFB};
    vecs[8]  = '{OP_LCD,        8'hFB};
    vecs[9]  = '{OP_INC,        8'hFC};
    vecs[10] = '{OP_BTN,        8'h00};
    vecs[11] = '{OP_DEC,        8'hFF};
    vecs[12] = '{OP_INC,        8'h00};
    vecs[13] = '{OP_LCD,        8'h00};
    vecs[14] = '{OP_INC,        8'h01};
    vecs[15] = '{OP_BOTH,       8'h00};
    vecs[16] = '{OP_LCD,        8'h00};

    // Reset state
    #100;
    check("rst_display", 32'(display), 32'd0);
    check("rst_dataout", 32'(lcd_dataout), 32'd0);
    check("rst_control", 32'(lcd_control), 32'd0);
    @(posedge clk_in); #1;
    nClear = 1'b0;

    // Power-up init and first screen update
    k = 0;
    while (cap.size() < 18 && k < 30000) begin cycles(1); k++; end
    check("init_strobes_seen", 32'(cap.size() >= 18), 32'd1);
    for (int i = 0; i < 18; i++) begin
      if (i < cap.size()) begin
        check($sformatf("init_nib%0d", i), 32'({cap[i].rs, cap[i].nib}),
              32'({init_tab[i].rs, init_tab[i].nib}));
        if (i > 0) check($sformatf("init_gap%0d", i), cap[i].gap, init_tab[i].gap);
      end
    end
    check("init_display", 32'(display), 32'd0);

    // Directed vectors
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].op == OP_LCD) begin
        check_lcd(vecs[i].exp_v);
      end else begin
        do_op(vecs[i].op);
        check($sformatf("vec%0d_v", i), 32'(display), 32'(vecs[i].exp_v));
      end
    end

    // Random rotary / button activity against the value model
    v_model = 8'h00;
    repeat (30) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        do_op(($urandom_range(0, 1) == 1) ? OP_BTN_BOUNCE : OP_BTN);
        v_model = 8'h00;
      end else if (r < 6) begin
        do_op(OP_INC);
        v_model = v_model + 8'd1;
      end else begin
        do_op(OP_DEC);
        v_model = v_model - 8'd1;
      end
      check("rand_v", 32'(display), 32'(v_model));
    end
    check_lcd(v_model);

    // Freeze with clk_en=0 in the middle of a strobe
    do_op(OP_INC);
    v_model = v_model + 8'd1;
    wait_e_high("freeze_e_seen");
    cycles(5);
    snap_disp = display;
    snap_data = lcd_dataout;
    snap_ctrl = lcd_control;
    clk_en = 1'b0;
    cycles(300);
    btn = 1'b1;
    cycles(100);
    btn = 1'b0;
    cycles(600);
    check("freeze_control", 32'(lcd_control), 32'(snap_ctrl));
    check("freeze_dataout", 32'(lcd_dataout), 32'(snap_data));
    check("freeze_display", 32'(display), 32'(snap_disp));
    clk_en = 1'b1;
    check_lcd(v_model);
    check("resume_v", 32'(display), 32'(v_model));

    // Reset in the middle of a write
    do_op(OP_INC);
    wait_e_high("rst_mid_e_seen");
    nClear = 1'b1;
    #1;
    check("rst_mid_control", 32'(lcd_control), 32'd0);
    check("rst_mid_display", 32'(display), 32'd0);
    check("rst_mid_dataout", 32'(lcd_dataout), 32'd0);
    cycles(5);
    cap.delete();
    nClear = 1'b0;
    k = 0;
    while (cap.size() < 18 && k < 30000) begin cycles(1); k++; end
    check("restart_strobes_seen", 32'(cap.size() >= 18), 32'd1);
    if (cap.size() >= 1) check("restart_first_nib", 32'({cap[0].rs, cap[0].nib}), 32'h03);
    check_lcd(8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mcu_single_cycle_lcd.md
MCU_SINGLE_CYCLE_LCD -- requirements
Module: mcu_single_cycle_lcd

Interface
REQ-001 Parameter: CLK_HZ, 50_000_000, clock frequency; all LCD and debounce delays SHALL be derived from it.
REQ-002 Parameter: DEB_CYC, 50_000, debounce stable-time in cycles (1 ms) for btn, rot_a, rot_b.
REQ-003 Port: clk_in, input, 1, single system clock; all state SHALL be on its rising edge.
REQ-004 Port: nClear, input, 1, reset; SHALL be asynchronous and active-high (nClear=1 resets).
REQ-005 Port: clk_en, input, 1, global enable; when 0, all registers, timers and FSMs SHALL hold.
REQ-006 Port: btn, input, 1, push button, asynchronous, bouncing.
REQ-007 Port: rot_a / rot_b, input, 1 each, rotary encoder quadrature, asynchronous, bouncing.
REQ-008 Port: display, output, 8, current value register V (LEDs).
REQ-009 Port: lcd_dataout, output, 4, LCD data nibble DB[7:4].
REQ-010 Port: lcd_control, output, 3, {[2]=E, [1]=RS, [0]=RW}; RW SHALL always be 0.

Function
REQ-011 btn, rot_a and rot_b SHALL each pass a 2-flop synchronizer, then a debouncer that updates its output only after the input is stable for DEB_CYC consecutive enabled cycles.
REQ-012 Debounced btn rising edge SHALL load V with 0x00 (one event per press).
REQ-013 Debounced rot_a rising edge with debounced rot_b=0 SHALL increment V; with rot_b=1 SHALL decrement V.
REQ-014 V SHALL wrap modulo 256 (0xFF+1=0x00, 0x00-1=0xFF); display = V at all times.
REQ-015 A btn event and a rotary event in the same cycle: btn SHALL win (V=0x00).
REQ-016 LCD FSM states: PWR_WAIT, INIT, IDLE, SET_ADDR, WR_HI, WR_LO, DONE.
REQ-017 PWR_WAIT: hold E=0 for 15 ms (750_000 cycles at 50 MHz), then INIT.
REQ-018 INIT SHALL send single nibbles 0x3 (wait 4.1 ms), 0x3 (wait 100 us), 0x3 (wait 40 us), 0x2 (wait 40 us), then bytes 0x28, 0x06, 0x0C, 0x01 (RS=0), waiting 40 us after each byte and 1.64 ms after 0x01.
REQ-019 Nibble write: drive lcd_dataout and RS; after 2 cycles setup raise E for 12 cycles; drop E; hold data 2 cycles.
REQ-020 Byte write: high nibble, 1 us gap, low nibble, then the post-byte wait (40 us unless stated).
REQ-021 After INIT and whenever V differs from the last value written: SET_ADDR writes 0x80 (RS=0), then writes ASCII hex of V[7:4] and V[3:0] (RS=1; '0'-'9'=0x30-0x39, 'A'-'F'=0x41-0x46), then returns to IDLE recording the written value.
REQ-022 A V change during a write SHALL not abort it; the new value SHALL be written in the next pass.
REQ-023 E SHALL never be high outside the 12-cycle strobe window.

Reset
REQ-024 While nClear=1: V=0x00, display=0x00, lcd_dataout=0x0, lcd_control=3'b000, debouncer outputs 0, synchronizers 0, FSM=PWR_WAIT, all timers 0.
REQ-025 Reset asserted mid-write SHALL immediately force E=0 and restart from PWR_WAIT on release.
REQ-026 After reset release the first screen update SHALL show "00".

Verification
REQ-027 Reset 100 ns then release, run 25 ms -> exact INIT nibble/byte sequence of REQ-018 on lcd_dataout with E pulses of 12 cycles, then 0x80, 0x30, 0x30; display=0x00.
REQ-028 btn pulse 250 us (with 5 us bounce) -> exactly one event, V=0x00, display=0x00.
REQ-029 Five sequences rot_b↑, rot_a↑, rot_b↓, rot_a↓ (250 us spacing) from V=0x00 -> V=0xFB, LCD last written 0x46('F'), 0x42('B').
REQ-030 Sequence rot_a↑, rot_b↑, rot_a↓, rot_b↓ from V=0xFF -> V=0x00; LCD rewritten "00".
REQ-031 clk_en=0 for 1 ms during a strobe -> E, lcd_dataout, V, timers frozen; resume exactly where held when clk_en=1.
REQ-032 btn press coinciding with rot_a rising edge (debounced same cycle) -> V=0x00.
